// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and helpers for the unified-SRAM port arbiter.
// Bus widths describe the flattened request payloads of the IF and MEM stages.
package mem_port_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   typedef enum logic {
      ARB_OWN_IF = 1'b0,
      ARB_OWN_DM = 1'b1
   } arb_owner_e;

   // req + addr
   localparam int IF_TO_ARB_BUS_WD  = 1 + 32;
   // req + we + addr + wdata
   localparam int MEM_TO_ARB_BUS_WD = 1 + 4 + 32 + 32;

   // A latency of 4 wraps to 0 in the 2-bit timer and still takes four cycles to reach 1.
   function automatic logic [1:0] lat_code(input int lat);
      logic [31:0] lat_bits;
      lat_bits = lat;
      return lat_bits[1:0];
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and SRAM-side signals around the arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic        if_rvalid;
   logic [31:0] if_rdata;

   logic        dm_req;
   logic [3:0]  dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ready;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;

   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_ready, if_rvalid, if_rdata, dm_ready, dm_rvalid, dm_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_ready, if_rvalid, if_rdata, dm_ready, dm_rvalid, dm_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/arb_lat_timer.sv
// Loadable 2-bit down-counter tracking the outstanding SRAM access.
// done flags the completion cycle (count of 1 while enabled).
module arb_lat_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       en,
   input  logic [1:0] load_val,
   output logic       done
);

   logic [1:0] cnt_reg;

   // Decrement wraps 0 -> 3 so a loaded 0 means four cycles.
   always_ff @(posedge clk) begin
      if (reset)
         cnt_reg <= 2'd0;
      else if (load)
         cnt_reg <= load_val;
      else if (en)
         cnt_reg <= cnt_reg - 2'd1;
   end

   assign done = en && (cnt_reg == 2'd1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port SRAM between instruction fetch and data access.
// Data wins by default; a starvation counter forces fetch after STARVE_MAX data grants.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   arb_state_e    state_reg, state_next;
   arb_owner_e    owner_reg, owner_next;
   logic          is_wr_reg, is_wr_next;
   logic [SW-1:0] starve_reg, starve_next;
   logic [31:0]   addr_reg, wdata_reg;

   logic done, busy, grant_window, starved, if_win, dm_win, grant;

   assign busy = (state_reg == ARB_BUSY);

   arb_lat_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (grant),
      .en       (busy),
      .load_val (lat_code(MEM_LAT)),
      .done     (done)
   );

   always_comb begin
      grant_window = !reset && (!busy || done);
      starved      = (starve_reg == SW'(STARVE_MAX));
      if_win       = grant_window && bus.if_req && (!bus.dm_req || starved);
      dm_win       = grant_window && bus.dm_req && !if_win;
      grant        = if_win || dm_win;
   end

   always_comb begin
      state_next  = state_reg;
      owner_next  = owner_reg;
      is_wr_next  = is_wr_reg;
      starve_next = starve_reg;

      if (grant) begin
         state_next = ARB_BUSY;
         owner_next = dm_win ? ARB_OWN_DM : ARB_OWN_IF;
         is_wr_next = dm_win && (bus.dm_we != 4'd0);
      end else if (done) begin
         state_next = ARB_IDLE;
      end

      if (if_win || !bus.if_req)
         starve_next = '0;
      else if (dm_win && !starved)
         starve_next = starve_reg + SW'(1);
   end

   always_comb begin
      bus.if_ready  = if_win;
      bus.dm_ready  = dm_win;
      bus.mem_en    = grant;
      bus.mem_we    = dm_win ? bus.dm_we : 4'd0;
      bus.mem_addr  = dm_win ? bus.dm_addr : (if_win ? bus.if_addr : addr_reg);
      bus.mem_wdata = dm_win ? bus.dm_wdata : wdata_reg;
      bus.if_rvalid = !reset && done && (owner_reg == ARB_OWN_IF);
      bus.dm_rvalid = !reset && done && (owner_reg == ARB_OWN_DM);
      bus.if_rdata  = bus.mem_rdata;
      // Store acks return zero rather than whatever the SRAM happens to present.
      bus.dm_rdata  = is_wr_reg ? 32'd0 : bus.mem_rdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ARB_IDLE;
         owner_reg  <= ARB_OWN_IF;
         is_wr_reg  <= 1'b0;
         starve_reg <= '0;
         addr_reg   <= 32'd0;
         wdata_reg  <= 32'd0;
      end else begin
         state_reg  <= state_next;
         owner_reg  <= owner_next;
         is_wr_reg  <= is_wr_next;
         starve_reg <= starve_next;
         addr_reg   <= bus.mem_addr;
         wdata_reg  <= bus.mem_wdata;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if b1 ();
   mem_port_arbiter_if b3 ();

   mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (b1.slave)
   );

   mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (b3.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [9:0] exp_if;

      reset = 1'b1;
      b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0;
      b1.dm_addr = 0; b1.dm_wdata = 0; b1.mem_rdata = 0;
      b3.if_req = 0; b3.if_addr = 0; b3.dm_req = 0; b3.dm_we = 0;
      b3.dm_addr = 0; b3.dm_wdata = 0; b3.mem_rdata = 0;
      step(); step();

      // Reset state, with a request presented while reset is still high
      b1.if_req = 1; b1.if_addr = 32'h44;
      sample();
      chk("rst_if_ready", {31'd0, b1.if_ready}, 32'd0);
      chk("rst_mem_en", {31'd0, b1.mem_en}, 32'd0);
      step();
      reset = 1'b0; b1.if_req = 0; b1.if_addr = 0;
      sample();
      chk("rst_mem_addr", b1.mem_addr, 32'd0);
      chk("rst_mem_wdata", b1.mem_wdata, 32'd0);
      chk("rst_mem_we", {28'd0, b1.mem_we}, 32'd0);
      chk("rst_rvalids", {30'd0, b1.if_rvalid, b1.dm_rvalid}, 32'd0);

      // IF only, MEM_LAT=1: three fetches, three completions in four cycles
      step();
      b1.if_req = 1; b1.if_addr = 32'h00;
      sample();
      chk("if0_ready", {31'd0, b1.if_ready}, 32'd1);
      chk("if0_addr", b1.mem_addr, 32'h00);
      chk("if0_mem_we", {28'd0, b1.mem_we}, 32'd0);
      chk("if0_rvalid", {31'd0, b1.if_rvalid}, 32'd0);
      step();
      b1.if_addr = 32'h04; b1.mem_rdata = 32'h1111_0000;
      sample();
      chk("if1_rvalid", {31'd0, b1.if_rvalid}, 32'd1);
      chk("if1_rdata", b1.if_rdata, 32'h1111_0000);
      chk("if1_ready", {31'd0, b1.if_ready}, 32'd1);
      chk("if1_addr", b1.mem_addr, 32'h04);
      step();
      b1.if_addr = 32'h08; b1.mem_rdata = 32'h2222_0004;
      sample();
      chk("if2_rvalid", {31'd0, b1.if_rvalid}, 32'd1);
      chk("if2_rdata", b1.if_rdata, 32'h2222_0004);
      chk("if2_addr", b1.mem_addr, 32'h08);
      step();
      b1.if_req = 0; b1.mem_rdata = 32'h3333_0008;
      sample();
      chk("if3_rvalid", {31'd0, b1.if_rvalid}, 32'd1);
      chk("if3_rdata", b1.if_rdata, 32'h3333_0008);
      chk("if3_mem_en", {31'd0, b1.mem_en}, 32'd0);
      chk("if3_addr_hold", b1.mem_addr, 32'h08);
      step();
      sample();
      chk("if4_idle_rvalid", {31'd0, b1.if_rvalid}, 32'd0);

      // Contention: DM wins, IF takes the completion cycle once DM drops
      step();
      b1.if_req = 1; b1.if_addr = 32'h40;
      b1.dm_req = 1; b1.dm_we = 4'd0; b1.dm_addr = 32'h100;
      sample();
      chk("ct0_dm_ready", {31'd0, b1.dm_ready}, 32'd1);
      chk("ct0_if_ready", {31'd0, b1.if_ready}, 32'd0);
      chk("ct0_addr", b1.mem_addr, 32'h100);
      step();
      b1.dm_req = 0; b1.mem_rdata = 32'hDEAD_BEEF;
      sample();
      chk("ct1_dm_rvalid", {31'd0, b1.dm_rvalid}, 32'd1);
      chk("ct1_dm_rdata", b1.dm_rdata, 32'hDEAD_BEEF);
      chk("ct1_if_ready", {31'd0, b1.if_ready}, 32'd1);
      chk("ct1_addr", b1.mem_addr, 32'h40);
      chk("ct1_if_rvalid", {31'd0, b1.if_rvalid}, 32'd0);
      step();
      b1.if_req = 0; b1.mem_rdata = 32'h0BAD_F00D;
      sample();
      chk("ct2_if_rvalid", {31'd0, b1.if_rvalid}, 32'd1);
      chk("ct2_if_rdata", b1.if_rdata, 32'h0BAD_F00D);
      chk("ct2_dm_rvalid", {31'd0, b1.dm_rvalid}, 32'd0);
      step();

      // Starvation guard: both held, IF forced every fifth grant
      exp_if = 10'b10000_10000;
      b1.if_req = 1; b1.if_addr = 32'h80;
      b1.dm_req = 1; b1.dm_we = 4'd0; b1.dm_addr = 32'h180;
      for (int i = 0; i < 10; i++) begin
         sample();
         chk($sformatf("sv%0d_if_ready", i), {31'd0, b1.if_ready}, {31'd0, exp_if[i]});
         chk($sformatf("sv%0d_dm_ready", i), {31'd0, b1.dm_ready}, {31'd0, ~exp_if[i]});
         step();
      end
      b1.if_req = 0; b1.dm_req = 0;
      step();

      // Store: byte strobe passed through, ack MEM_LAT later, no fetch ack
      b1.dm_req = 1; b1.dm_we = 4'b0010; b1.dm_addr = 32'h200; b1.dm_wdata = 32'h0000_AB00;
      sample();
      chk("st0_dm_ready", {31'd0, b1.dm_ready}, 32'd1);
      chk("st0_mem_we", {28'd0, b1.mem_we}, 32'h2);
      chk("st0_wdata", b1.mem_wdata, 32'h0000_AB00);
      chk("st0_addr", b1.mem_addr, 32'h200);
      step();
      b1.dm_req = 0; b1.dm_we = 4'd0;
      sample();
      chk("st1_dm_rvalid", {31'd0, b1.dm_rvalid}, 32'd1);
      chk("st1_if_rvalid", {31'd0, b1.if_rvalid}, 32'd0);
      chk("st1_mem_we", {28'd0, b1.mem_we}, 32'd0);
      chk("st1_wdata_hold", b1.mem_wdata, 32'h0000_AB00);
      step();
      sample();
      chk("st2_rvalids", {30'd0, b1.if_rvalid, b1.dm_rvalid}, 32'd0);

      // MEM_LAT=3: back-to-back loads accepted at T and T+3
      step();
      b3.dm_req = 1; b3.dm_addr = 32'h300;
      sample();
      chk("l3_t0_ready", {31'd0, b3.dm_ready}, 32'd1);
      step();
      b3.dm_addr = 32'h304;
      sample();
      chk("l3_t1_ready", {31'd0, b3.dm_ready}, 32'd0);
      chk("l3_t1_rvalid", {31'd0, b3.dm_rvalid}, 32'd0);
      step();
      sample();
      chk("l3_t2_ready", {31'd0, b3.dm_ready}, 32'd0);
      chk("l3_t2_mem_en", {31'd0, b3.mem_en}, 32'd0);
      step();
      b3.mem_rdata = 32'h0000_00A3;
      sample();
      chk("l3_t3_rvalid", {31'd0, b3.dm_rvalid}, 32'd1);
      chk("l3_t3_rdata", b3.dm_rdata, 32'h0000_00A3);
      chk("l3_t3_ready", {31'd0, b3.dm_ready}, 32'd1);
      chk("l3_t3_addr", b3.mem_addr, 32'h304);
      step();
      b3.dm_req = 0;
      sample();
      chk("l3_t4_rvalid", {31'd0, b3.dm_rvalid}, 32'd0);
      step();
      sample();
      chk("l3_t5_rvalid", {31'd0, b3.dm_rvalid}, 32'd0);
      step();
      b3.mem_rdata = 32'h0000_00B6;
      sample();
      chk("l3_t6_rvalid", {31'd0, b3.dm_rvalid}, 32'd1);
      chk("l3_t6_rdata", b3.dm_rdata, 32'h0000_00B6);
      step();
      sample();
      chk("l3_t7_rvalid", {31'd0, b3.dm_rvalid}, 32'd0);

      // Reset at T+1 of a MEM_LAT=3 load drops the completion
      step();
      b3.dm_req = 1; b3.dm_addr = 32'h400;
      sample();
      chk("rm_t0_ready", {31'd0, b3.dm_ready}, 32'd1);
      step();
      b3.dm_req = 0; reset = 1'b1;
      sample();
      chk("rm_t1_mem_en", {31'd0, b3.mem_en}, 32'd0);
      chk("rm_t1_rvalid", {31'd0, b3.dm_rvalid}, 32'd0);
      step();
      reset = 1'b0; b3.if_req = 1; b3.if_addr = 32'h500;
      sample();
      chk("rm_t2_if_ready", {31'd0, b3.if_ready}, 32'd1);
      chk("rm_t2_addr", b3.mem_addr, 32'h500);
      chk("rm_t2_dm_rvalid", {31'd0, b3.dm_rvalid}, 32'd0);
      step();
      b3.if_req = 0;
      sample();
      chk("rm_t3_dm_rvalid", {31'd0, b3.dm_rvalid}, 32'd0);
      chk("rm_t3_if_rvalid", {31'd0, b3.if_rvalid}, 32'd0);
      step();
      sample();
      chk("rm_t4_if_rvalid", {31'd0, b3.if_rvalid}, 32'd0);
      step();
      b3.mem_rdata = 32'h0000_0C05;
      sample();
      chk("rm_t5_if_rvalid", {31'd0, b3.if_rvalid}, 32'd1);
      chk("rm_t5_if_rdata", b3.if_rdata, 32'h0000_0C05);
      chk("rm_t5_dm_rvalid", {31'd0, b3.dm_rvalid}, 32'd0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
